// File: rtl/operand_gen.sv
// operand_gen: LFSR-driven operand/opcode source that issues a counted run of
// operand sets to a downstream datapath and tracks that datapath's latency.
module operand_gen #(
  parameter int          N    = 16,
  parameter int          PIPE = 0,
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  count,
  input  logic         rand_op,
  input  logic [2:0]   op_in,
  input  logic         stall,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [2:0]   opcode,
  output logic         issue_valid,
  output logic         res_valid,
  output logic         busy,
  output logic         done,
  output logic [15:0]  issued
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  localparam logic [31:0] POLY       = 32'h8020_0003;
  localparam logic [31:0] LOAD_A     = (SEED == 32'd0) ? 32'h0000_0001 : SEED;
  localparam logic [31:0] LOAD_B     = (SEED == 32'd0) ? 32'hFFFF_FFFE : ~SEED;
  localparam logic [1:0]  DRAIN_LAST = (PIPE <= 1) ? 2'd0 : 2'(PIPE - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] lfsr_a;
  logic [31:0] lfsr_b;
  logic [15:0] cap_count;
  logic        cap_rand;
  logic [2:0]  cap_op;
  logic [1:0]  drain_cnt;
  logic        fire;
  logic [15:0] issued_inc;

  // One Galois step of the right-shifting 32-bit LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? POLY : 32'd0);
  endfunction

  assign fire       = (state == RUN) && !stall;
  assign issued_inc = (issued == 16'hFFFF) ? 16'hFFFF : issued + 16'd1;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a run ends on the issue that brings issued up to count.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = (count == 16'd0) ? DONE : RUN;
      RUN:     if (fire && (issued_inc == cap_count)) state_next = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counts cycles spent in DRAIN so the FSM waits out the datapath latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              drain_cnt <= 2'd0;
    else if (state != DRAIN) drain_cnt <= 2'd0;
    else                     drain_cnt <= drain_cnt + 2'd1;
  end

  // Run capture in LOAD, then operand issue and LFSR advance on unstalled RUN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A           <= '0;
      B           <= '0;
      opcode      <= 3'd0;
      issue_valid <= 1'b0;
      issued      <= 16'd0;
      lfsr_a      <= SEED;
      lfsr_b      <= ~SEED;
      cap_count   <= 16'd0;
      cap_rand    <= 1'b0;
      cap_op      <= 3'd0;
    end else begin
      issue_valid <= 1'b0;
      if (state == LOAD) begin
        cap_count <= count;
        cap_rand  <= rand_op;
        cap_op    <= op_in;
        lfsr_a    <= LOAD_A;
        lfsr_b    <= LOAD_B;
        issued    <= 16'd0;
      end else if (fire) begin
        A           <= lfsr_a[N-1:0];
        B           <= lfsr_b[N-1:0];
        opcode      <= cap_rand ? lfsr_a[31:29] : cap_op;
        issue_valid <= 1'b1;
        lfsr_a      <= lfsr_step(lfsr_a);
        lfsr_b      <= lfsr_step(lfsr_b);
        issued      <= issued_inc;
      end
    end
  end

  generate
    if (PIPE == 0) begin : g_nopipe
      assign res_valid = issue_valid;
    end else begin : g_pipe
      logic [PIPE-1:0] dly;

      // Free-running delay line mirroring the datapath latency.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly <= '0;
        end else begin
          dly[0] <= issue_valid;
          for (int i = 1; i < PIPE; i++) dly[i] <= dly[i-1];
        end
      end

      assign res_valid = dly[PIPE-1];
    end
  endgenerate

endmodule

// File: tb/tb_operand_gen.sv
// tb_operand_gen: directed checks of operand_gen with a zero-latency and a
// two-cycle-latency instance driven from the same stimulus.
module tb_operand_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] count;
  logic        rand_op;
  logic [2:0]  op_in;
  logic        stall;

  logic [15:0] a_0, b_0, issued_0;
  logic [2:0]  opcode_0;
  logic        issue_valid_0, res_valid_0, busy_0, done_0;
  logic [15:0] a_2, b_2, issued_2;
  logic [2:0]  opcode_2;
  logic        issue_valid_2, res_valid_2, busy_2, done_2;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_a [3];
  logic [15:0] exp_b [3];
  logic [2:0]  exp_op [3];
  logic [5:0]  iv_exp, rv_exp, done_exp;
  int          done_cnt;
  logic        iv_seen;
  logic        found;

  operand_gen #(.N(16), .PIPE(0), .SEED(32'h0000_0001)) u_gen0 (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count), .rand_op(rand_op),
    .op_in(op_in), .stall(stall), .A(a_0), .B(b_0), .opcode(opcode_0),
    .issue_valid(issue_valid_0), .res_valid(res_valid_0), .busy(busy_0),
    .done(done_0), .issued(issued_0)
  );

  operand_gen #(.N(16), .PIPE(2), .SEED(32'h0000_0001)) u_gen2 (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count), .rand_op(rand_op),
    .op_in(op_in), .stall(stall), .A(a_2), .B(b_2), .opcode(opcode_2),
    .issue_valid(issue_valid_2), .res_valid(res_valid_2), .busy(busy_2),
    .done(done_2), .issued(issued_2)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] c, input logic r,
                               input logic [2:0] o, input logic st);
    start   = s;
    count   = c;
    rand_op = r;
    op_in   = o;
    stall   = st;
  endtask

  task automatic resetBoth();
    applyStimulus(1'b0, 16'd0, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Directed sequence; cycle comments count edges from the start request.
  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b0, 3'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] reset values");
    checkOutput("rst_A", 32'(a_0), 32'd0);
    checkOutput("rst_B", 32'(b_0), 32'd0);
    checkOutput("rst_opcode", 32'(opcode_0), 32'd0);
    checkOutput("rst_issue_valid", 32'(issue_valid_0), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid_0), 32'd0);
    checkOutput("rst_done", 32'(done_0), 32'd0);
    checkOutput("rst_busy", 32'(busy_0), 32'd0);
    checkOutput("rst_issued", 32'(issued_0), 32'd0);
    checkOutput("rst_res_valid_p2", 32'(res_valid_2), 32'd0);
    checkOutput("rst_busy_p2", 32'(busy_2), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] count=2 random opcode");
    applyStimulus(1'b1, 16'd2, 1'b1, 3'd0, 1'b0);
    tick();
    checkOutput("load_busy", 32'(busy_0), 32'd1);
    applyStimulus(1'b0, 16'd2, 1'b1, 3'd0, 1'b0);
    tick();
    checkOutput("run_no_issue", 32'(issue_valid_0), 32'd0);
    tick();
    checkOutput("i1_valid", 32'(issue_valid_0), 32'd1);
    checkOutput("i1_res_valid_p0", 32'(res_valid_0), 32'd1);
    checkOutput("i1_A", 32'(a_0), 32'h0001);
    checkOutput("i1_B", 32'(b_0), 32'hFFFE);
    checkOutput("i1_opcode", 32'(opcode_0), 32'd0);
    checkOutput("i1_issued", 32'(issued_0), 32'd1);
    tick();
    checkOutput("i2_A", 32'(a_0), 32'h0003);
    checkOutput("i2_B", 32'(b_0), 32'hFFFF);
    checkOutput("i2_opcode", 32'(opcode_0), 32'd4);
    checkOutput("i2_issued", 32'(issued_0), 32'd2);
    checkOutput("i2_A_p2", 32'(a_2), 32'h0003);
    checkOutput("i2_B_p2", 32'(b_2), 32'hFFFF);
    tick();
    checkOutput("done_p0", 32'(done_0), 32'd1);
    checkOutput("drain_no_issue", 32'(issue_valid_0), 32'd0);
    checkOutput("res1_p2", 32'(res_valid_2), 32'd1);
    tick();
    checkOutput("done_clear_p0", 32'(done_0), 32'd0);
    checkOutput("idle_busy_p0", 32'(busy_0), 32'd0);
    checkOutput("final_issued", 32'(issued_0), 32'd2);
    checkOutput("res2_p2", 32'(res_valid_2), 32'd1);
    checkOutput("done_p2", 32'(done_2), 32'd1);
    tick();
    checkOutput("idle_busy_p2", 32'(busy_2), 32'd0);

    $display("[TB] PIPE=2 fixed opcode count=3");
    resetBoth();
    iv_exp   = 6'b000111;
    rv_exp   = 6'b011100;
    done_exp = 6'b010000;
    applyStimulus(1'b1, 16'd3, 1'b0, 3'b011, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd3, 1'b0, 3'b011, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("p2_iv_c%0d", i + 3), 32'(issue_valid_2), 32'(iv_exp[i]));
      checkOutput($sformatf("p2_rv_c%0d", i + 3), 32'(res_valid_2), 32'(rv_exp[i]));
      checkOutput($sformatf("p2_done_c%0d", i + 3), 32'(done_2), 32'(done_exp[i]));
      if (iv_exp[i]) checkOutput($sformatf("p2_op_c%0d", i + 3), 32'(opcode_2), 32'd3);
    end
    checkOutput("p2_issued", 32'(issued_2), 32'd3);

    $display("[TB] stall after first issue");
    resetBoth();
    exp_a  = '{16'h0003, 16'h0002, 16'h0001};
    exp_b  = '{16'hFFFF, 16'hFFFC, 16'hFFFE};
    exp_op = '{3'd4, 3'd6, 3'd3};
    applyStimulus(1'b1, 16'd4, 1'b1, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd4, 1'b1, 3'd0, 1'b0);
    tick();
    tick();
    checkOutput("st_first_A", 32'(a_0), 32'h0001);
    applyStimulus(1'b0, 16'd4, 1'b1, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("st_iv_%0d", i), 32'(issue_valid_0), 32'd0);
      checkOutput($sformatf("st_A_%0d", i), 32'(a_0), 32'h0001);
      checkOutput($sformatf("st_B_%0d", i), 32'(b_0), 32'hFFFE);
      checkOutput($sformatf("st_issued_%0d", i), 32'(issued_0), 32'd1);
    end
    applyStimulus(1'b0, 16'd4, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("st_post_iv_%0d", i), 32'(issue_valid_0), 32'd1);
      checkOutput($sformatf("st_post_A_%0d", i), 32'(a_0), 32'(exp_a[i]));
      checkOutput($sformatf("st_post_B_%0d", i), 32'(b_0), 32'(exp_b[i]));
      checkOutput($sformatf("st_post_op_%0d", i), 32'(opcode_0), 32'(exp_op[i]));
    end
    tick();
    checkOutput("st_done", 32'(done_0), 32'd1);
    checkOutput("st_issued", 32'(issued_0), 32'd4);

    $display("[TB] count=0");
    resetBoth();
    applyStimulus(1'b1, 16'd0, 1'b0, 3'd0, 1'b0);
    tick();
    checkOutput("c0_busy", 32'(busy_0), 32'd1);
    applyStimulus(1'b0, 16'd0, 1'b0, 3'd0, 1'b0);
    iv_seen  = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) checkOutput("c0_done", 32'(done_0), 32'd1);
      iv_seen  = iv_seen | issue_valid_0;
      done_cnt = done_cnt + int'(done_0);
    end
    checkOutput("c0_no_issue", 32'(iv_seen), 32'd0);
    checkOutput("c0_done_count", 32'(done_cnt), 32'd1);
    checkOutput("c0_issued", 32'(issued_0), 32'd0);
    checkOutput("c0_idle", 32'(busy_0), 32'd0);

    $display("[TB] reset mid-run");
    resetBoth();
    applyStimulus(1'b1, 16'd10, 1'b1, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd10, 1'b1, 3'd0, 1'b0);
    repeat (6) tick();
    checkOutput("mr_issued5", 32'(issued_0), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mr_A", 32'(a_0), 32'd0);
    checkOutput("mr_B", 32'(b_0), 32'd0);
    checkOutput("mr_opcode", 32'(opcode_0), 32'd0);
    checkOutput("mr_iv", 32'(issue_valid_0), 32'd0);
    checkOutput("mr_busy", 32'(busy_0), 32'd0);
    checkOutput("mr_issued", 32'(issued_0), 32'd0);
    checkOutput("mr_done", 32'(done_0), 32'd0);
    checkOutput("mr_rv_p2", 32'(res_valid_2), 32'd0);
    checkOutput("mr_iv_p2", 32'(issue_valid_2), 32'd0);
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      done_cnt = done_cnt + int'(done_0) + int'(done_2);
    end
    checkOutput("mr_no_done", 32'(done_cnt), 32'd0);
    checkOutput("mr_idle", 32'(busy_0), 32'd0);
    applyStimulus(1'b1, 16'd1, 1'b1, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd1, 1'b1, 3'd0, 1'b0);
    tick();
    tick();
    checkOutput("mr_restart_A", 32'(a_0), 32'h0001);
    checkOutput("mr_restart_B", 32'(b_0), 32'hFFFE);

    $display("[TB] start held during run");
    resetBoth();
    applyStimulus(1'b1, 16'd2, 1'b1, 3'd0, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      done_cnt = done_cnt + int'(done_0);
      if (i == 3) checkOutput("hold_issued", 32'(issued_0), 32'd2);
      if (i == 5) checkOutput("hold_idle", 32'(busy_0), 32'd0);
    end
    checkOutput("hold_one_done", 32'(done_cnt), 32'd1);
    tick();
    checkOutput("hold_second_run", 32'(busy_0), 32'd1);
    applyStimulus(1'b0, 16'd2, 1'b1, 3'd0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (done_0) found = 1'b1;
    end
    checkOutput("second_run_done", 32'(found), 32'd1);
    checkOutput("second_run_issued", 32'(issued_0), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_gen.md
OPERAND_GEN -- requirements
Module: operand_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N, 16, operand width (2..32).
- PIPE, 0, latency of the downstream datapath in cycles (0, 1 or 2).
- SEED, 32'h0000_0001, LFSR seed.
REQ-002 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a run (sampled only in IDLE).
- count, in, 16, number of operand sets to issue.
- rand_op, in, 1, 1 = random opcode, 0 = use op_in.
- op_in, in, 3, fixed opcode.
- stall, in, 1, suppress issue this cycle.
- A, out, N, operand A to the datapath.
- B, out, N, operand B to the datapath.
- opcode, out, 3, opcode to the datapath.
- issue_valid, out, 1, A/B/opcode are a new set this cycle.
- res_valid, out, 1, the datapath Y/co is valid this cycle.
- busy, out, 1, FSM not in IDLE.
- done, out, 1, one-cycle completion pulse.
- issued, out, 16, sets issued in the current run.

Function
REQ-004 FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
REQ-005 IDLE: start=1 -> LOAD; start is ignored in every other state.
REQ-006 LOAD (1 cycle): capture count, rand_op and op_in; load lfsr_a=SEED and lfsr_b=~SEED (a seed of 0 substitutes 1 for lfsr_a and 32'hFFFF_FFFE for lfsr_b); clear issued; go to RUN, or to DONE if the captured count==0.
REQ-007 RUN, stall=0 at a clock edge: register A=lfsr_a[N-1:0], B=lfsr_b[N-1:0], opcode = captured rand_op ? lfsr_a[31:29] : captured op_in; assert issue_valid; advance both LFSRs once; increment issued.
REQ-008 RUN, stall=1: A/B/opcode hold, issue_valid=0, LFSRs and issued hold.
REQ-009 LFSR step (Galois, right shift): next = (x>>1) ^ (x[0] ? 32'h8020_0003 : 0).
REQ-010 RUN -> DRAIN on the edge that issues the set making issued==captured count.
REQ-011 DRAIN: issue_valid=0; stay exactly PIPE cycles (0 means pass through in 1 cycle), then go to DONE.
REQ-012 DONE (1 cycle): done=1, then IDLE; issued keeps its final value until the next LOAD.
REQ-013 res_valid equals issue_valid delayed by PIPE cycles through a free-running shift register (PIPE=0: combinational copy).
REQ-014 busy=1 in LOAD, RUN, DRAIN and DONE.
REQ-015 issued saturates at 16'hFFFF; count=16'hFFFF completes normally.
REQ-016 Back-to-back runs: start asserted in the cycle after DONE is accepted, since the FSM is then in IDLE.

Reset
REQ-017 rst_n=0 forces, immediately and asynchronously: state=IDLE, A=0, B=0, opcode=0, issue_valid=0, res_valid=0, delay line=0, done=0, busy=0, issued=0, lfsr_a=SEED, lfsr_b=~SEED.
REQ-018 Reset asserted mid-RUN or mid-DRAIN abandons the run; no done pulse; in-flight res_valid bits are cleared.

Verification
REQ-019 N=16, PIPE=0, SEED=1, count=2, rand_op=1, stall=0 -> issue 1: A=16'h0001, B=16'hFFFE, opcode=0; issue 2: A=16'h0003, B=16'hFFFF, opcode=3'd4; done 1 cycle after the last issue; issued=2.
REQ-020 PIPE=2, count=3, rand_op=0, op_in=3'b011 -> three issue_valid pulses with opcode=3; res_valid pulses exactly 2 cycles after each; done follows the last res_valid.
REQ-021 count=4, stall high for 3 cycles after the first issue -> A/B held, issue_valid=0 during the stall; total issued=4; LFSR sequence identical to the unstalled run.
REQ-022 count=0 -> LOAD then DONE; done pulses once; issue_valid never asserts; issued=0.
REQ-023 rst_n pulsed low while issued=5 of count=10 -> all outputs 0 at once; no done; a following start restarts from SEED values.
REQ-024 start asserted continuously during RUN -> ignored; exactly one run completes; a second run begins only after returning to IDLE.
